// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the raw lines,
// then assembles 11-bit frames into bytes with parity/stop/timeout checking.
module ps2_byte_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             clk_meta_q, clk_sync_q;
  logic             data_meta_q, data_sync_q;
  logic             filt_clk_q, filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fe, sd;

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [ToW-1:0]   to_cnt_q;
  logic [7:0]       shreg_q;
  logic             parity_q;

  // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_clk_q;
      if (clk_sync_q == filt_clk_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltMax) begin
        filt_clk_q <= clk_sync_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fe = filt_prev_q & ~filt_clk_q;
  assign sd = data_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      out_byte   <= 8'h00;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      // Timeout takes priority over a coincident falling edge.
      if (state_q != StIdle && to_cnt_q == ToMax) begin
        frame_err <= 1'b1;
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        to_cnt_q  <= '0;
        shreg_q   <= '0;
      end else begin
        if (state_q == StIdle || fe) begin
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + ToW'(1);
        end
        if (fe) begin
          unique case (state_q)
            StIdle: begin
              if (!sd) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
              end
            end
            StData: begin
              shreg_q   <= {sd, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StParity;
              end
            end
            StParity: begin
              parity_q <= sd;
              state_q  <= StStop;
            end
            StStop: begin
              state_q <= StIdle;
              if (!sd) begin
                frame_err <= 1'b1;
              end else if ((^shreg_q ^ parity_q) == 1'b1) begin
                out_byte   <= shreg_q;
                byte_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Directed bench for ps2_byte_rx: good frames, parity/stop errors, timeout,
// clock glitch rejection, mid-frame reset and back-to-back frames.
module tb_ps2_byte_rx;

  localparam int unsigned FiltLen = 4;
  localparam int unsigned Timeout = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] out_byte;
  logic       byte_valid, parity_err, frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_perr   = 0;
  int n_ferr   = 0;
  int n_multi  = 0;
  logic [7:0] got_bytes[$];

  ps2_byte_rx #(
    .FILTER_LEN    (FiltLen),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .out_byte  (out_byte),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      n_valid++;
      got_bytes.push_back(out_byte);
    end
    if (parity_err) n_perr++;
    if (frame_err) n_ferr++;
    if (int'(byte_valid) + int'(parity_err) + int'(frame_err) > 1) n_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  int v0, p0, f0, first_ferr;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset out_byte", 32'(out_byte), 32'h00);
    check_eq("reset pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: 8'h08, odd parity bit 0
    send_frame(8'h08, 1'b0, 1'b1);
    check_eq("t1 valid count", n_valid, 1);
    check_eq("t1 out_byte", 32'(out_byte), 32'h08);
    check_eq("t1 no perr", n_perr, 0);
    check_eq("t1 no ferr", n_ferr, 0);

    // 2: 8'hFF good, then 8'h08 with bad parity
    send_frame(8'hFF, 1'b1, 1'b1);
    check_eq("t2 out_byte FF", 32'(out_byte), 32'hFF);
    check_eq("t2 valid count", n_valid, 2);
    send_frame(8'h08, 1'b1, 1'b1);
    check_eq("t2 perr count", n_perr, 1);
    check_eq("t2 out_byte held", 32'(out_byte), 32'hFF);
    check_eq("t2 valid unchanged", n_valid, 2);
    check_eq("t2 no ferr", n_ferr, 0);

    // 3: 8'h5A with stop bit 0 (parity correct)
    send_frame(8'h5A, 1'b1, 1'b0);
    check_eq("t3 ferr count", n_ferr, 1);
    check_eq("t3 perr unchanged", n_perr, 1);
    check_eq("t3 valid unchanged", n_valid, 2);
    check_eq("t3 out_byte held", 32'(out_byte), 32'hFF);

    // 4: start + 4 data bits then idle; time the last falling edge to the timeout pulse
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    first_ferr = 0;
    // 2 sync + FILTER_LEN filter + 1 fe cycle, then TIMEOUT_CYCLES to the pulse
    for (int c = 1; c <= int'(3 + FiltLen + Timeout) + 40; c++) begin
      @(negedge clk);
      if (c == 10) begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
      end
      if (frame_err && first_ferr == 0) first_ferr = c;
    end
    check_eq("t4 timeout cycle", first_ferr, 3 + FiltLen + Timeout);
    check_eq("t4 ferr count", n_ferr, 2);
    send_frame(8'h3C, 1'b1, 1'b1);
    check_eq("t4 out_byte 3C", 32'(out_byte), 32'h3C);
    check_eq("t4 valid count", n_valid, 3);

    // 5: 2-cycle low glitch with data low must not start a frame
    ps2_data = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b1);
    check_eq("t5 glitch out_byte", 32'(out_byte), 32'hA5);
    check_eq("t5 glitch valid count", n_valid, 4);
    check_eq("t5 glitch ferr", n_ferr, 2);

    // Reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    reset = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t5 reset out_byte", 32'(out_byte), 32'h00);
    check_eq("t5 reset pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (int'(Timeout) + 20) @(negedge clk);
    check_eq("t5 post-reset pulses", n_valid + n_perr + n_ferr, v0 + p0 + f0);
    check_eq("t5 post-reset out_byte", 32'(out_byte), 32'h00);

    // 6: back-to-back frames
    got_bytes.delete();
    send_frame(8'h09, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    check_eq("t6 byte count", got_bytes.size(), 3);
    if (got_bytes.size() == 3) begin
      check_eq("t6 byte0", 32'(got_bytes[0]), 32'h09);
      check_eq("t6 byte1", 32'(got_bytes[1]), 32'h12);
      check_eq("t6 byte2", 32'(got_bytes[2]), 32'h34);
    end
    check_eq("t6 no errors", n_perr + n_ferr, p0 + f0);
    check_eq("pulse exclusivity", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
